// File: rtl/tile_map_scheduler_if.sv
// tile_map_scheduler_if: bundles the control, map RAM and tile drawer signals of the map scheduler.
// The master modport is the scheduler side; slave is the game logic / RAM / drawer side.
interface tile_map_scheduler_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [8:0]  tiles_drawn;
  logic [8:0]  map_addr;
  logic [7:0]  map_data;
  logic        drawer_active;
  logic        drawer_draw;
  logic [11:0] drawer_tile_address;
  logic [7:0]  drawer_x_pos;
  logic [7:0]  drawer_y_pos;

  modport master (
    input  start, map_data, drawer_active,
    output busy, done, tiles_drawn, map_addr,
           drawer_draw, drawer_tile_address, drawer_x_pos, drawer_y_pos
  );

  modport slave (
    output start, map_data, drawer_active,
    input  busy, done, tiles_drawn, map_addr,
           drawer_draw, drawer_tile_address, drawer_x_pos, drawer_y_pos
  );
endinterface

// File: rtl/tile_map_scheduler.sv
// tile_map_scheduler: walks the tile map row-major and launches one tile drawer job per cell.
// Optional macro SKIP_EMPTY_TILE_EN: cells holding tile id 0 are skipped without a draw.
module tile_map_scheduler #(
  parameter int MAP_COLS   = 20,
  parameter int MAP_ROWS   = 15,
  parameter int TILE_BYTES = 192,
  parameter int TILE_PX    = 8
) (
  input  logic                clk,
  input  logic                resetn,
  tile_map_scheduler_if.master bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WAIT_MAP  = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_ADVANCE   = 3'd5;
  localparam logic [2:0] S_DONE      = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [7:0]  col_q, col_d;
  logic [7:0]  row_q, row_d;
  logic [8:0]  map_addr_q, map_addr_d;
  logic [8:0]  tiles_drawn_q, tiles_drawn_d;
  logic [11:0] tile_addr_q, tile_addr_d;
  logic [7:0]  x_pos_q, x_pos_d;
  logic [7:0]  y_pos_q, y_pos_d;
  logic        draw_q, draw_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        first_wait_q, first_wait_d;

  logic last_col;
  logic last_row;
  logic skip_tile;

  assign last_col = (col_q == 8'(MAP_COLS - 1));
  assign last_row = (row_q == 8'(MAP_ROWS - 1));

`ifdef SKIP_EMPTY_TILE_EN
  assign skip_tile = (bus.map_data == 8'd0);
`else
  assign skip_tile = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    map_addr_d    = map_addr_q;
    tiles_drawn_d = tiles_drawn_q;
    tile_addr_d   = tile_addr_q;
    x_pos_d       = x_pos_q;
    y_pos_d       = y_pos_q;
    draw_d        = draw_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    first_wait_d  = first_wait_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          col_d         = 8'd0;
          row_d         = 8'd0;
          tiles_drawn_d = 9'd0;
          map_addr_d    = 9'd0;
          busy_d        = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT_MAP;
      S_WAIT_MAP: begin
        if (skip_tile) begin
          state_d = S_ADVANCE;
        end else begin
          // Products are truncated on purpose: large ids alias within the 4 KiB ROM.
          tile_addr_d = 12'(32'(bus.map_data) * 32'(TILE_BYTES));
          x_pos_d     = 8'(32'(col_q) * 32'(TILE_PX));
          y_pos_d     = 8'(32'(row_q) * 32'(TILE_PX));
          draw_d      = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.drawer_active) begin
          draw_d        = 1'b0;
          tiles_drawn_d = tiles_drawn_q + 9'd1;
          first_wait_d  = 1'b1;
          state_d       = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // The cycle right after the handshake cannot signal completion.
        first_wait_d = 1'b0;
        if (!first_wait_q && !bus.drawer_active) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (last_col) begin
          col_d = 8'd0;
          row_d = row_q + 8'd1;
        end else begin
          col_d = col_q + 8'd1;
        end
        if (last_col && last_row) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          map_addr_d = map_addr_q + 9'd1;
          state_d    = S_FETCH;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      col_q         <= 8'd0;
      row_q         <= 8'd0;
      map_addr_q    <= 9'd0;
      tiles_drawn_q <= 9'd0;
      tile_addr_q   <= 12'd0;
      x_pos_q       <= 8'd0;
      y_pos_q       <= 8'd0;
      draw_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      first_wait_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      map_addr_q    <= map_addr_d;
      tiles_drawn_q <= tiles_drawn_d;
      tile_addr_q   <= tile_addr_d;
      x_pos_q       <= x_pos_d;
      y_pos_q       <= y_pos_d;
      draw_q        <= draw_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      first_wait_q  <= first_wait_d;
    end
  end

  assign bus.map_addr            = map_addr_q;
  assign bus.tiles_drawn         = tiles_drawn_q;
  assign bus.drawer_tile_address = tile_addr_q;
  assign bus.drawer_x_pos        = x_pos_q;
  assign bus.drawer_y_pos        = y_pos_q;
  assign bus.drawer_draw         = draw_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;

endmodule

// File: tb/tb_tile_map_scheduler.sv
// tb_tile_map_scheduler: randomized frames on a 2x2 map, scoreboarded against a per-cell reference model.
// Honours SKIP_EMPTY_TILE_EN the same way the design does.
module tb_tile_map_scheduler;

  localparam int COLS       = 2;
  localparam int ROWS       = 2;
  localparam int CELLS      = COLS * ROWS;
  localparam int TILE_BYTES = 192;
  localparam int TILE_PX    = 8;
`ifdef SKIP_EMPTY_TILE_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic clk;
  logic resetn;
  tile_map_scheduler_if bus ();

  tile_map_scheduler #(
    .MAP_COLS(COLS), .MAP_ROWS(ROWS), .TILE_BYTES(TILE_BYTES), .TILE_PX(TILE_PX)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  map_mem [0:511];
  logic [27:0] exp_draws [$];
  int          exp_frames [$];
  int          checks_total  = 0;
  int          checks_passed = 0;
  int          done_seen     = 0;
  int          drawer_delay  = 2;
  int          drawer_len    = 10;
  int          last_expected = 0;

  // Map RAM: one cycle read latency.
  always @(posedge clk) bus.map_data <= map_mem[bus.map_addr];

  // Drawer: raises active drawer_delay cycles after seeing draw, holds it drawer_len cycles.
  initial begin
    bus.drawer_active = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.drawer_draw === 1'b1) begin
        repeat (drawer_delay) @(negedge clk);
        bus.drawer_active = 1'b1;
        repeat (drawer_len) @(negedge clk);
        bus.drawer_active = 1'b0;
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({bus.map_addr, bus.drawer_draw, bus.drawer_tile_address, bus.drawer_x_pos,
                bus.drawer_y_pos, bus.busy, bus.done, bus.tiles_drawn});
  endfunction

  // Reference model: one draw per cell in row-major order, id 0 skipped only when enabled.
  task automatic expect_frame();
    int n = 0;
    for (int i = 0; i < CELLS; i++) begin
      int id = int'(map_mem[i]);
      if (SKIP_EN && id == 0) continue;
      exp_draws.push_back({12'(id * TILE_BYTES), 8'((i % COLS) * TILE_PX), 8'((i / COLS) * TILE_PX)});
      n++;
    end
    exp_frames.push_back(n);
    last_expected = n;
  endtask

  task automatic apply_stimulus();
    expect_frame();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_for_done();
    bit seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_output("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_frame_checks(input int done_before);
    repeat (3) @(negedge clk);
    check_output("busy_after_frame", 64'(bus.busy), 64'd0);
    check_output("tiles_drawn_after", 64'(bus.tiles_drawn), 64'(last_expected));
    check_output("done_pulses", 64'(done_seen - done_before), 64'd1);
  endtask

  task automatic load_map(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    map_mem[0] = a; map_mem[1] = b; map_mem[2] = c; map_mem[3] = d;
  endtask

  // Monitor: pops expected draws on each new draw request and frame counts on each done.
  initial begin
    logic prev_draw = 1'b0;
    int   high_cnt  = 0;
    forever begin
      @(negedge clk);
      if (resetn !== 1'b1) begin
        prev_draw = 1'b0;
        high_cnt  = 0;
        continue;
      end
      if (bus.drawer_draw === 1'b1) begin
        if (!prev_draw) begin
          high_cnt = 1;
          if (exp_draws.size() == 0) begin
            checks_total++;
            $display("[TB] FAIL unexpected_draw: addr=%0d x=%0d y=%0d with no draw expected",
                     bus.drawer_tile_address, bus.drawer_x_pos, bus.drawer_y_pos);
          end else begin
            check_output("draw_addr_x_y",
                         64'({bus.drawer_tile_address, bus.drawer_x_pos, bus.drawer_y_pos}),
                         64'(exp_draws.pop_front()));
          end
        end else begin
          high_cnt++;
        end
      end else if (prev_draw) begin
        check_output("draw_hold_cycles", 64'(high_cnt), 64'(drawer_delay + 1));
      end
      if (bus.done === 1'b1) begin
        done_seen++;
        if (exp_frames.size() == 0) begin
          checks_total++;
          $display("[TB] FAIL unexpected_done: tiles_drawn=%0d with no frame expected", bus.tiles_drawn);
        end else begin
          check_output("tiles_drawn_at_done", 64'(bus.tiles_drawn), 64'(exp_frames.pop_front()));
          check_output("busy_at_done", 64'(bus.busy), 64'd1);
        end
      end
      prev_draw = bus.drawer_draw;
    end
  end

  initial begin
    int d0;
    for (int i = 0; i < 512; i++) map_mem[i] = 8'd0;
    resetn    = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_outputs", all_outputs(), 64'd0);
    resetn = 1'b1;

    // Idle without start: nothing moves.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output("idle_outputs", all_outputs(), 64'd0);
    end

    // Basic frame.
    load_map(8'd1, 8'd2, 8'd3, 8'd4);
    drawer_delay = 2; drawer_len = 10;
    d0 = done_seen;
    apply_stimulus();
    wait_for_done();
    finish_frame_checks(d0);

    // Slow drawer: request must be held until active is seen.
    drawer_delay = 50; drawer_len = 3;
    d0 = done_seen;
    apply_stimulus();
    wait_for_done();
    finish_frame_checks(d0);

    // Start while busy and in the done cycle is ignored.
    drawer_delay = 3; drawer_len = 4;
    d0 = done_seen;
    apply_stimulus();
    repeat (6) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_for_done();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    finish_frame_checks(d0);

    // Start in the first idle cycle after done begins a new frame.
    d0 = done_seen;
    apply_stimulus();
    wait_for_done();
    @(negedge clk);
    apply_stimulus();
    check_output("busy_restart", 64'(bus.busy), 64'd1);
    wait_for_done();
    finish_frame_checks(d0 + 1);

    // Reset while the third cell is in progress.
    drawer_delay = 2; drawer_len = 10;
    load_map(8'd9, 8'd10, 8'd11, 8'd12);
    apply_stimulus();
    begin
      int   rises = 0;
      logic prev  = 1'b0;
      bit   found = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        @(negedge clk);
        if (bus.drawer_draw && !prev) rises++;
        if (rises == 3 && prev && !bus.drawer_draw) begin
          found = 1'b1;
          break;
        end
        prev = bus.drawer_draw;
      end
      check_output("reached_cell2_wait", 64'(found), 64'd1);
    end
    resetn = 1'b0;
    @(negedge clk);
    check_output("abort_outputs", all_outputs(), 64'd0);
    exp_draws.delete();
    exp_frames.delete();
    resetn = 1'b1;
    for (int c = 0; c < 200 && bus.drawer_active; c++) @(negedge clk);
    d0 = done_seen;
    apply_stimulus();
    wait_for_done();
    finish_frame_checks(d0);

    // Randomized maps and drawer timing.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < CELLS; i++)
        map_mem[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      drawer_delay = int'($urandom_range(1, 5));
      drawer_len   = int'($urandom_range(1, 6));
      d0 = done_seen;
      apply_stimulus();
      wait_for_done();
      finish_frame_checks(d0);
    end

    // Empty tiles.
    load_map(8'd0, 8'd5, 8'd0, 8'd7);
    drawer_delay = 2; drawer_len = 5;
    d0 = done_seen;
    apply_stimulus();
    wait_for_done();
    finish_frame_checks(d0);

    repeat (5) @(negedge clk);
    check_output("draw_queue_empty", 64'(exp_draws.size()), 64'd0);
    check_output("frame_queue_empty", 64'(exp_frames.size()), 64'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/tile_map_scheduler.md
Name: tile_map_scheduler

Overview:
Sequences the tile drawer across a full screen tile map. On `start`, walks a MAP_COLS x MAP_ROWS tile map row-major, one cell at a time:
- reads each tile id from map RAM;
- converts it to a tile ROM base address and screen pixel position;
- launches one tile draw and waits until the drawer finishes.

Sits between game logic (which fills map RAM and pulses `start`) and the single tile drawer that owns the VGA bus.

Parameters:
MAP_COLS, 20, tiles per row (160 px / 8)
MAP_ROWS, 15, tile rows (120 px / 8)
TILE_BYTES, 192, ROM bytes per tile (64 px x 3 bytes RGB)
TILE_PX, 8, tile edge in pixels (power of two)

Ports:
clk  input  1  system clock, all logic on posedge
resetn  input  1  synchronous active-low reset
start  input  1  one-cycle request to draw the whole map; ignored while busy
map_addr  output  9  map RAM read address, row*MAP_COLS+col
map_data  input  8  tile id; valid exactly 1 cycle after map_addr is presented
drawer_active  input  1  drawer busy flag (high from its load state until the tile completes)
drawer_draw  output  1  draw request to drawer, level held until drawer_active seen high
drawer_tile_address  output  12  ROM base address of tile
drawer_x_pos  output  8  tile pixel x = col*TILE_PX
drawer_y_pos  output  8  tile pixel y = row*TILE_PX
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse when last cell is finished
tiles_drawn  output  9  count of draws issued in current/last frame

Behaviour:
- Reset (resetn=0 at posedge): state IDLE.
  - All outputs 0: map_addr, drawer_draw, drawer_tile_address, drawer_x_pos, drawer_y_pos, busy, done, tiles_drawn.
  - Col/row counters 0.
  - Reset mid-frame aborts immediately; drawer_draw drops the next cycle. The drawer itself is not reset by this block.
- IDLE: start=1 -> clear col/row/tiles_drawn, busy<=1, map_addr<=0, go FETCH.
- FETCH: map_addr holds current cell; go WAIT_MAP (1-cycle RAM latency).
- WAIT_MAP: capture map_data as tile_id.
  - drawer_tile_address <= (tile_id*TILE_BYTES)[11:0]. Full product is 16 bits, truncated mod 4096; ids >= 22 alias, no error flag.
  - drawer_x_pos <= col*TILE_PX, drawer_y_pos <= row*TILE_PX, truncated to 8 bits.
  - Go ISSUE.
- ISSUE: drawer_draw=1; address/pos outputs stable.
  - drawer_active=1 -> drawer_draw<=0, tiles_drawn+1, go WAIT_DONE.
  - Otherwise stay; no timeout.
- WAIT_DONE: wait for drawer_active=0, then go ADVANCE.
  - The first cycle in WAIT_DONE is never treated as completion; at least one cycle is spent here.
- ADVANCE: col+1.
  - col==MAP_COLS-1 -> col<=0, row+1.
  - Last cell (col==MAP_COLS-1 && row==MAP_ROWS-1) -> go DONE.
  - Else update map_addr (+1, linear) and go FETCH.
- DONE: done=1 for exactly one cycle, busy<=0, go IDLE.
  - start in this cycle is ignored.
  - start in the following IDLE cycle begins a new frame.
- Outputs are registered; drawer_tile_address/x/y hold their last values in IDLE.
- drawer_draw is never high in any state other than ISSUE.
- Throughput: per-tile overhead is 4 cycles plus the drawer's tile time.

Optional Feature:
SKIP_EMPTY_TILE_EN:
- Defined: in WAIT_MAP, tile_id==0 goes directly to ADVANCE. No draw is issued and tiles_drawn is not incremented; position/address outputs are not updated.
- Undefined: id 0 is drawn like any other tile (ROM address 0).

Test Plan:
1. Reset then idle, start never asserted -> all outputs 0 for 20 cycles, drawer_draw never 1.
2. MAP_COLS=2, MAP_ROWS=2, map={1,2,3,4}, drawer model asserts active 2 cycles after draw for 10 cycles -> four draws with (addr,x,y) = (192,0,0), (384,8,0), (576,0,8), (768,8,8); done pulses once; tiles_drawn=4; busy low after.
3. Drawer model delays drawer_active by 50 cycles -> drawer_draw held high for all 50 cycles, drops the cycle after active seen, exactly one draw counted.
4. start pulsed during a frame and in the DONE cycle -> ignored (single done, tiles_drawn=4); start in the next IDLE cycle -> new frame from map_addr=0.
5. resetn low during WAIT_DONE of cell 2 -> next cycle all outputs 0, state IDLE; a following start redraws from cell 0.
6. SKIP_EMPTY_TILE_EN defined, map={0,5,0,7} -> only draws (960,8,0) and (1344,8,8), tiles_drawn=2. Undefined -> 4 draws, the first at addr 0.
